// File: rtl/psram_qpi_responder.sv
// PSRAM device-side responder: SPI QPI-enable, QPI write/read/exit, small on-chip byte array.
// Optional power-up lockout is built when PSRAM_RESP_INIT_DELAY_EN is defined.
module psram_qpi_responder #(
    parameter int ADDR_WIDTH        = 10,
    parameter int WAIT_CYCLES       = 6,
    parameter int INIT_DELAY_CYCLES = 30000
) (
    input  logic       i_clkRAM,
    input  logic       reset,
    input  logic       i_psram_cs,
    input  logic [3:0] i_sio,
    output logic [3:0] o_sio,
    output logic       o_sio_oe,
    output logic       o_qpi_mode,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_SPI_CMD, S_QPI_CMD, S_ADDR, S_WR_DATA, S_RD_WAIT, S_RD_DATA, S_DISCARD
    } state_t;

    localparam int CNT_MAX = (WAIT_CYCLES > 8) ? WAIT_CYCLES : 8;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SPI_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(5);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [6:0]              cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    is_rd_q, is_rd_d;
    logic                    phase_q, phase_d;
    logic [3:0]              sio_q, sio_d;
    logic                    sio_oe_q, sio_oe_d;
    logic                    qpi_mode_q, qpi_mode_d;
    logic                    err_q, err_d;

    logic [7:0]              mem [2**ADDR_WIDTH];
    logic                    mem_we;
    logic [7:0]              mem_wdata;
    logic [7:0]              rd_byte;
    logic [7:0]              spi_byte;
    logic [7:0]              qpi_byte;
    logic                    busy;

`ifdef PSRAM_RESP_INIT_DELAY_EN
    localparam int INIT_W = $clog2(INIT_DELAY_CYCLES + 1);
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;

    always_comb begin
        init_cnt_d = init_cnt_q;
        if (init_cnt_q != '0) init_cnt_d = init_cnt_q - INIT_W'(1);
    end

    always_ff @(posedge i_clkRAM or negedge reset) begin
        if (!reset) init_cnt_q <= INIT_W'(INIT_DELAY_CYCLES);
        else        init_cnt_q <= init_cnt_d;
    end

    assign busy = (init_cnt_q != '0);
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        is_rd_d    = is_rd_q;
        phase_d    = phase_q;
        sio_d      = sio_q;
        sio_oe_d   = 1'b0;
        qpi_mode_d = qpi_mode_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        rd_byte    = mem[addr_q];
        spi_byte   = {cmd_q, i_sio[0]};
        qpi_byte   = {cmd_q[3:0], i_sio};
        // During a write burst cmd_q[3:0] holds the pending high data nibble.
        mem_wdata  = {cmd_q[3:0], i_sio};

        if (i_psram_cs || busy) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = CNT_W'(1);
                    if (qpi_mode_q) begin
                        cmd_d   = {3'b000, i_sio};
                        state_d = S_QPI_CMD;
                    end else begin
                        cmd_d   = {6'b000000, i_sio[0]};
                        state_d = S_SPI_CMD;
                    end
                end
                S_SPI_CMD: begin
                    cmd_d = spi_byte[6:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == SPI_LAST) begin
                        state_d = S_DISCARD;
                        if (spi_byte == 8'h35) qpi_mode_d = 1'b1;
                        else                   err_d      = 1'b1;
                    end
                end
                S_QPI_CMD: begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_DISCARD;
                    case (qpi_byte)
                        8'h38: begin is_rd_d = 1'b0; state_d = S_ADDR; end
                        8'hEB: begin is_rd_d = 1'b1; state_d = S_ADDR; end
                        8'hF5: qpi_mode_d = 1'b0;
                        default: err_d = 1'b1;
                    endcase
                end
                S_ADDR: begin
                    addr_d = {addr_q[ADDR_WIDTH-5:0], i_sio};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (!is_rd_q)              state_d = S_WR_DATA;
                        else if (WAIT_CYCLES == 0) state_d = S_RD_DATA;
                        else                       state_d = S_RD_WAIT;
                    end
                end
                S_WR_DATA: begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        cmd_d = {3'b000, i_sio};
                    end else begin
                        mem_we = 1'b1;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
                S_RD_WAIT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == WAIT_LAST) state_d = S_RD_DATA;
                end
                S_RD_DATA: begin
                    sio_oe_d = 1'b1;
                    phase_d  = ~phase_q;
                    if (!phase_q) begin
                        sio_d = rd_byte[7:4];
                    end else begin
                        sio_d  = rd_byte[3:0];
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
                S_DISCARD: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clkRAM or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            is_rd_q    <= 1'b0;
            phase_q    <= 1'b0;
            sio_q      <= 4'h0;
            sio_oe_q   <= 1'b0;
            qpi_mode_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            is_rd_q    <= is_rd_d;
            phase_q    <= phase_d;
            sio_q      <= sio_d;
            sio_oe_q   <= sio_oe_d;
            qpi_mode_q <= qpi_mode_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; contents survive a reset pulse.
    always_ff @(posedge i_clkRAM) begin
        if (mem_we) mem[addr_q] <= mem_wdata;
    end

    assign o_sio      = sio_q;
    assign o_sio_oe   = sio_oe_q;
    assign o_qpi_mode = qpi_mode_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Randomized self-checking bench for psram_qpi_responder against a byte-array reference model.
module tb_psram_qpi_responder;

    localparam int AW    = 10;
    localparam int WAITC = 6;
    localparam int INITC = 30000;
    localparam int DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cs_n = 1'b1;
    logic [3:0] sio_i = 4'h0;
    logic [3:0] o_sio;
    logic       o_sio_oe;
    logic       o_qpi_mode;
    logic       o_err;

    logic [7:0] mem_model [DEPTH];
    logic [7:0] wbuf [8];
    int checks = 0;
    int failures = 0;

    psram_qpi_responder #(
        .ADDR_WIDTH(AW), .WAIT_CYCLES(WAITC), .INIT_DELAY_CYCLES(INITC)
    ) dut (
        .i_clkRAM  (clk),
        .reset     (reset),
        .i_psram_cs(cs_n),
        .i_sio     (sio_i),
        .o_sio     (o_sio),
        .o_sio_oe  (o_sio_oe),
        .o_qpi_mode(o_qpi_mode),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap(input logic [23:0] a, input int i);
        return (int'(a) + i) % DEPTH;
    endfunction

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic tick(input logic cs, input logic [3:0] sio);
        cs_n  = cs;
        sio_i = sio;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b1, 4'h0);
        check("idle_oe", o_sio_oe, 1'b0);
    endtask

    task automatic wait_init();
`ifdef PSRAM_RESP_INIT_DELAY_EN
        repeat (INITC) tick(1'b1, 4'h0);
`endif
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            tick(1'b0, {3'b000, b[i]});
            check("spi_oe", o_sio_oe, 1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick(1'b0, b[7:4]);
        tick(1'b0, b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) tick(1'b0, a[i*4 +: 4]);
    endtask

    // Write n bytes from wbuf; dangle adds a lone high nibble that must not be stored.
    task automatic qpi_write(input logic [23:0] a, input int n, input logic dangle);
        send_byte(8'h38);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i]);
            mem_model[wrap(a, i)] = wbuf[i];
        end
        if (dangle) tick(1'b0, 4'($urandom));
        idle();
    endtask

    task automatic qpi_read(input logic [23:0] a, input int n);
        logic [7:0] exp_b;
        send_byte(8'hEB);
        send_addr(a);
        repeat (WAITC) tick(1'b0, 4'($urandom));
        check("rd_wait_oe", o_sio_oe, 1'b0);
        for (int i = 0; i < n; i++) begin
            exp_b = mem_model[wrap(a, i)];
            tick(1'b0, 4'h0);
            check("rd_oe_hi", o_sio_oe, 1'b1);
            check("rd_hi", o_sio, exp_b[7:4]);
            tick(1'b0, 4'h0);
            check("rd_oe_lo", o_sio_oe, 1'b1);
            check("rd_lo", o_sio, exp_b[3:0]);
        end
        idle();
    endtask

    initial begin
        logic [23:0] ra;
        int          n;
        int          m;

        repeat (2) @(posedge clk);
        #1;
        check("rst_oe", o_sio_oe, 1'b0);
        check("rst_qpi", o_qpi_mode, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_sio", o_sio, 4'h0);
        reset = 1'b1;

`ifdef PSRAM_RESP_INIT_DELAY_EN
        spi_cmd(8'h35);
        check("init_lockout_qpi", o_qpi_mode, 1'b0);
        idle();
        wait_init();
`endif

        // QPI enable: mode flips on the 8th bit, never before.
        for (int i = 7; i >= 1; i--) begin
            tick(1'b0, {3'b000, 1'(8'h35 >> i)});
            check("en_oe", o_sio_oe, 1'b0);
        end
        check("en_qpi_early", o_qpi_mode, 1'b0);
        tick(1'b0, 4'h1);
        check("en_qpi", o_qpi_mode, 1'b1);
        check("en_err", o_err, 1'b0);
        idle();
        check("en_qpi_hold", o_qpi_mode, 1'b1);

        // Write/read with address truncation.
        wbuf[0] = 8'hAA;
        qpi_write(24'h00C000, 1, 1'b0);
        qpi_read(24'h00C000, 1);
        qpi_read(24'h000000, 1);

        // Burst wrap at the top of the array.
        wbuf[0] = 8'h12;
        wbuf[1] = 8'h34;
        qpi_write(24'h0003FF, 2, 1'b0);
        qpi_read(24'h0003FF, 2);

        // Abort after the 3rd address nibble of a write.
        send_byte(8'h38);
        tick(1'b0, 4'h0);
        tick(1'b0, 4'h0);
        tick(1'b0, 4'h0);
        idle();
        qpi_read(24'h000000, 1);

        // Unsupported QPI command: one-cycle error, rest of transfer ignored.
        send_byte(8'h99);
        check("err_pulse", o_err, 1'b1);
        send_byte(8'h38);
        check("err_once", o_err, 1'b0);
        send_addr(24'h000000);
        send_byte(8'h55);
        check("discard_oe", o_sio_oe, 1'b0);
        idle();
        check("err_qpi_kept", o_qpi_mode, 1'b1);
        qpi_read(24'h000000, 1);

        // Randomized bursts, each followed by a partial rewrite that stops mid-byte.
        for (int it = 0; it < 16; it++) begin
            ra = 24'($urandom);
            n  = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            qpi_write(ra, n, 1'b0);
            m  = int'($urandom_range(0, n - 1));
            for (int i = 0; i < m; i++) wbuf[i] = 8'($urandom);
            qpi_write(ra, m, 1'b1);
            qpi_read(ra, n);
        end

        // Exit QPI, then an unsupported SPI command, then re-enable.
        tick(1'b0, 4'hF);
        check("exit_early", o_qpi_mode, 1'b1);
        tick(1'b0, 4'h5);
        check("exit_qpi", o_qpi_mode, 1'b0);
        idle();
        spi_cmd(8'h12);
        check("spi_err", o_err, 1'b1);
        tick(1'b0, 4'h0);
        check("spi_err_once", o_err, 1'b0);
        idle();
        check("spi_err_mode", o_qpi_mode, 1'b0);
        spi_cmd(8'h35);
        check("reen_qpi", o_qpi_mode, 1'b1);
        idle();

        // Reset asserted during RD_DATA acts without a clock edge.
        send_byte(8'hEB);
        send_addr(24'h0003FF);
        repeat (WAITC) tick(1'b0, 4'h0);
        tick(1'b0, 4'h0);
        check("mid_rd_oe", o_sio_oe, 1'b1);
        reset = 1'b0;
        #1;
        check("arst_oe", o_sio_oe, 1'b0);
        check("arst_qpi", o_qpi_mode, 1'b0);
        check("arst_sio", o_sio, 4'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        wait_init();
        spi_cmd(8'h35);
        check("post_rst_qpi", o_qpi_mode, 1'b1);
        idle();
        qpi_read(24'h0003FF, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psram_qpi_responder.md
# psram_qpi_responder

Synthesizable single-chip PSRAM responder for the GM64 memory subsystem. It is the device end of the SPI/QPI link that `memCtrl` drives: it decodes the SPI-mode QPI-enable command and the QPI write, read and exit commands, and holds a small on-chip byte array. It serves as a drop-in PSRAM stand-in for simulation and for FPGA builds that have no external PSRAM fitted.

## Interface
- `ADDR_WIDTH`, 10: byte array depth is 2^ADDR_WIDTH; upper address bits are ignored.
- `WAIT_CYCLES`, 6: dummy cycles between the last read-address nibble and the first read-data nibble.
- `INIT_DELAY_CYCLES`, 30000: power-up lockout length. Used only with `PSRAM_RESP_INIT_DELAY_EN`.
- `i_clkRAM`  in  1  RAM clock. Acts as SCLK; all sampling happens on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_psram_cs`  in  1  chip select, active low.
- `i_sio`  in  4  SIO[3:0] from the initiator. Only SIO0 is used in SPI mode.
- `o_sio`  out  4  read data nibble.
- `o_sio_oe`  out  1  output enable for `o_sio`; the pad is tri-stated when this is 0.
- `o_qpi_mode`  out  1  1 while the device is in QPI mode.
- `o_err`  out  1  one-cycle pulse on an unsupported command.

## Operation
- Reset values: `o_sio`=0, `o_sio_oe`=0, `o_qpi_mode`=0, `o_err`=0, state=IDLE. Array contents are not reset.
- A `i_psram_cs`=1 sample at any state forces IDLE and clears `o_sio_oe`. Any partial address or data is discarded; no array write happens for an incomplete byte.
- States: IDLE, SPI_CMD, QPI_CMD, ADDR, WR_DATA, RD_WAIT, RD_DATA, DISCARD.
- SPI mode (`o_qpi_mode`=0):
  - The first sample with `i_psram_cs`=0 enters SPI_CMD.
  - 8 bits are shifted from SIO0, MSB first.
  - 0x35 sets `o_qpi_mode`=1 when the command completes, then goes to DISCARD.
  - Any other byte pulses `o_err` and goes to DISCARD.
- QPI mode:
  - Command is 2 nibbles, high nibble first. 0x38 = write, 0xEB = read, 0xF5 = exit QPI.
  - Exit clears `o_qpi_mode` and goes to DISCARD. Other commands pulse `o_err` and go to DISCARD.
  - ADDR: 6 nibbles (A23..A0, MSB first). Only A[ADDR_WIDTH-1:0] is kept.
  - WR_DATA: nibble pairs, high nibble first. Each completed byte is written to mem[addr], then addr increments. Burst continues while cs stays low; addr wraps modulo 2^ADDR_WIDTH.
  - RD_WAIT: counts exactly WAIT_CYCLES samples, then enters RD_DATA.
  - RD_DATA: drives mem[addr] high nibble, then low nibble, then the next address. Same wrap rule as writes. `o_sio_oe`=1 throughout.
- DISCARD: ignores all input until cs goes high.

## Timing
- Outputs are registered and change only after a rising edge of `i_clkRAM`.
- Array write lands on the same edge that samples the low data nibble. A read issued afterwards returns the new value.
- Read latency, counted from the edge that samples the last address nibble:
  - The first read-data nibble is valid after edge WAIT_CYCLES+1.
  - The initiator samples it on the next edge.
- `o_qpi_mode` changes on the edge that samples the final command bit/nibble.
- `o_err` is high for exactly one cycle.
- Reset asserted mid-transfer: outputs return to their reset values immediately (asynchronously). QPI mode is lost.

## Configuration
- `PSRAM_RESP_INIT_DELAY_EN` defined:
  - A counter loads INIT_DELAY_CYCLES on reset and decrements each cycle.
  - While the counter is nonzero, `i_psram_cs` is ignored and the state stays IDLE.
  - This models the PSRAM power-up time that `memCtrl` waits out.
- Not defined: no counter is built, and the device accepts commands on the first edge after reset release.

## Test plan
- QPI enable:
  - Stimulus: cs low; SIO0 = 0,0,1,1,0,1,0,1 over 8 edges; then cs high.
  - Required: `o_qpi_mode`=1, `o_err`=0, `o_sio_oe` never 1.
- QPI write:
  - Stimulus: nibbles 3,8, 0,0,C,0,0,0, A,A (addr 0x00C000, data 0xAA).
  - Required: mem[0x000]=0xAA (ADDR_WIDTH=10 truncation).
- QPI read:
  - Stimulus: nibbles E,B, 0,0,C,0,0,0, then 6 wait edges.
  - Required: `o_sio_oe`=1 with `o_sio`=A, then A, on consecutive cycles.
- Burst write wrap:
  - Stimulus: write at 0x0003FF with data 0x12 then 0x34.
  - Required: mem[0x3FF]=0x12, mem[0x000]=0x34.
- Aborts:
  - Stimulus: cs high after the 3rd address nibble of a write.
  - Required: no array change; next command is decoded normally.
  - Stimulus: command 0x99 in QPI mode.
  - Required: `o_err` high for exactly one cycle; input ignored until cs high.
- Reset mid-read:
  - Stimulus: `reset` low during RD_DATA.
  - Required: `o_sio_oe`=0, `o_qpi_mode`=0 without waiting for a clock edge.
  - With `PSRAM_RESP_INIT_DELAY_EN`: commands issued before INIT_DELAY_CYCLES elapse are ignored.
